// File: rtl/ex_forward_datapath_pkg.sv
// Shared definitions for the 8-bit MIPS execution datapath: widths,
// forwarding-select encodings and the pipeline stage record.
package mips_pkg;

    localparam int DW = 8;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    localparam logic [4:0] OP_BUBBLE = 5'b00000;

    typedef struct packed {
        logic          valid;
        logic [4:0]    op;
        logic [AW-1:0] rw;
        logic [DW-1:0] res;
        logic          load;
        logic          store;
        logic [DW-1:0] sdata;
    } stage_t;

endpackage

// File: rtl/ex_forward_datapath_if.sv
// Decode-side inputs, ALU/data-memory/register-file ports of the execution
// datapath, bundled so the decode stage and the datapath share one bus.
interface ex_forward_datapath_if;

    logic [1:0]                 mux_sel_a;
    logic [1:0]                 mux_sel_b;
    logic                       imm_sel;
    logic [mips_pkg::DW-1:0]    Imm;
    logic [4:0]                 op_dec;
    logic [mips_pkg::AW-1:0]    RW_dec;
    logic                       mem_en_dec;
    logic                       mem_rw_dec;
    logic [mips_pkg::DW-1:0]    rf_a;
    logic [mips_pkg::DW-1:0]    rf_b;
    logic [mips_pkg::DW-1:0]    alu_res;
    logic [mips_pkg::DW-1:0]    dm_rdata;

    logic [mips_pkg::DW-1:0]    opnd_a;
    logic [mips_pkg::DW-1:0]    opnd_b;
    logic [4:0]                 op_ex;
    logic [mips_pkg::DW-1:0]    dm_addr;
    logic [mips_pkg::DW-1:0]    dm_wdata;
    logic                       dm_en;
    logic                       dm_we;
    logic                       wb_we;
    logic [mips_pkg::AW-1:0]    wb_addr;
    logic [mips_pkg::DW-1:0]    wb_data;
    logic [7:0]                 fwd_cnt;

    modport master (
        output mux_sel_a, mux_sel_b, imm_sel, Imm, op_dec, RW_dec,
               mem_en_dec, mem_rw_dec, rf_a, rf_b, alu_res, dm_rdata,
        input  opnd_a, opnd_b, op_ex, dm_addr, dm_wdata, dm_en, dm_we,
               wb_we, wb_addr, wb_data, fwd_cnt
    );

    modport slave (
        input  mux_sel_a, mux_sel_b, imm_sel, Imm, op_dec, RW_dec,
               mem_en_dec, mem_rw_dec, rf_a, rf_b, alu_res, dm_rdata,
        output opnd_a, opnd_b, op_ex, dm_addr, dm_wdata, dm_en, dm_we,
               wb_we, wb_addr, wb_data, fwd_cnt
    );

endinterface

// File: rtl/ex_forward_datapath_fwd_mux.sv
// 4:1 operand select between register file and in-flight stage results;
// a selected stage holding a bubble falls back to the register-file value.
module operand_fwd_mux
    import mips_pkg::*;
(
    input  logic [1:0]    sel,
    input  logic [DW-1:0] rf_data,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_res,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_res,
    input  logic          wb_valid,
    input  logic [DW-1:0] wb_res,
    output logic [DW-1:0] opnd,
    output logic          fwd_used
);

    always_comb begin
        opnd     = rf_data;
        fwd_used = 1'b0;
        case (fwd_sel_e'(sel))
            FWD_RF: ;
            FWD_EX: if (ex_valid) begin
                opnd     = ex_res;
                fwd_used = 1'b1;
            end
            FWD_MEM: if (mem_valid) begin
                opnd     = mem_res;
                fwd_used = 1'b1;
            end
            FWD_WB: if (wb_valid) begin
                opnd     = wb_res;
                fwd_used = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ex_forward_datapath.sv
// EX/MEM/WB pipeline registers with operand forwarding, data-memory port
// driven from EX and register-file write port driven from WB.
module ex_forward_datapath
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    ex_forward_datapath_if.slave bus
);

    stage_t        ex_q, mem_q, wb_q;
    stage_t        ex_d, mem_d;
    logic [DW-1:0] fwd_a, fwd_b;
    logic          use_a, use_b_raw, use_b;
    logic [8:0]    cnt_sum;
    logic [7:0]    fwd_cnt_q;
    logic          wb_unused;

    operand_fwd_mux u_fwd_a (
        .sel       (bus.mux_sel_a),
        .rf_data   (bus.rf_a),
        .ex_valid  (ex_q.valid),
        .ex_res    (ex_q.res),
        .mem_valid (mem_q.valid),
        .mem_res   (mem_q.res),
        .wb_valid  (wb_q.valid),
        .wb_res    (wb_q.res),
        .opnd      (fwd_a),
        .fwd_used  (use_a)
    );

    operand_fwd_mux u_fwd_b (
        .sel       (bus.mux_sel_b),
        .rf_data   (bus.rf_b),
        .ex_valid  (ex_q.valid),
        .ex_res    (ex_q.res),
        .mem_valid (mem_q.valid),
        .mem_res   (mem_q.res),
        .wb_valid  (wb_q.valid),
        .wb_res    (wb_q.res),
        .opnd      (fwd_b),
        .fwd_used  (use_b_raw)
    );

    // The immediate replaces B after forwarding, so a forwarded B that the
    // immediate overrides is not counted but is still the store value.
    assign use_b      = use_b_raw & ~bus.imm_sel;
    assign bus.opnd_a = fwd_a;
    assign bus.opnd_b = bus.imm_sel ? bus.Imm : fwd_b;
    assign bus.op_ex  = bus.op_dec;

    always_comb begin
        ex_d = '0;
        if (bus.op_dec != OP_BUBBLE) begin
            ex_d.valid = 1'b1;
            ex_d.op    = bus.op_dec;
            ex_d.rw    = bus.RW_dec;
            ex_d.res   = bus.alu_res;
            ex_d.load  = bus.mem_en_dec & ~bus.mem_rw_dec;
            ex_d.store = bus.mem_en_dec &  bus.mem_rw_dec;
            ex_d.sdata = fwd_b;
        end
    end

    always_comb begin
        mem_d = ex_q;
        if (ex_q.load) begin
            mem_d.res = bus.dm_rdata;
        end
    end

    assign cnt_sum = {1'b0, fwd_cnt_q} + {8'd0, use_a} + {8'd0, use_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= mem_q;
            fwd_cnt_q <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

    assign bus.dm_addr  = ex_q.res;
    assign bus.dm_wdata = ex_q.sdata;
    assign bus.dm_en    = ex_q.valid & (ex_q.load | ex_q.store);
    assign bus.dm_we    = ex_q.valid & ex_q.store;

    assign bus.wb_we    = wb_q.valid & ~wb_q.store;
    assign bus.wb_addr  = wb_q.rw;
    assign bus.wb_data  = wb_q.res;
    assign bus.fwd_cnt  = fwd_cnt_q;

    // WB keeps the full record; these fields have no consumer past WB.
    assign wb_unused = ^{wb_q.op, wb_q.load, wb_q.sdata};

endmodule

// File: tb/tb_ex_forward_datapath.sv
// Directed bench for ex_forward_datapath: a per-cycle instruction log model
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_ex_forward_datapath;

    logic clk;
    logic reset;

    ex_forward_datapath_if bus ();

    ex_forward_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction log indexed by issue cycle; stage k cycles back is entry cyc-k.
    int         cyc  = 0;
    int         kill = 0;
    int         mcnt = 0;
    bit         lv  [1024];
    bit         lld [1024];
    bit         lst [1024];
    logic [4:0] lrw [1024];
    logic [7:0] lalu[1024];
    logic [7:0] lmres[1024];
    logic [7:0] lsd [1024];

    function automatic bit mvalid(input int k);
        return (k >= 0) && (k < 1024) && (k >= kill) && lv[k];
    endfunction

    function automatic logic [7:0] model_fwd(input logic [1:0] sel, input logic [7:0] rf,
                                             output bit used);
        int k;
        used = 1'b0;
        model_fwd = rf;
        if (sel != 2'b00) begin
            k = cyc - int'(sel);
            if (mvalid(k)) begin
                used = 1'b1;
                model_fwd = (sel == 2'b01) ? lalu[k] : lmres[k];
            end
        end
    endfunction

    always @(negedge reset) begin
        kill = cyc;
        mcnt = 0;
    end

    always @(posedge clk) begin
        bit ua, ub;
        logic [7:0] vb;
        int n;
        if (reset === 1'b1) begin
            void'(model_fwd(bus.mux_sel_a, bus.rf_a, ua));
            vb = model_fwd(bus.mux_sel_b, bus.rf_b, ub);
            n = int'(ua) + int'(ub && !bus.imm_sel);
            mcnt = (mcnt + n > 255) ? 255 : mcnt + n;
            if (mvalid(cyc - 1))
                lmres[cyc-1] = lld[cyc-1] ? bus.dm_rdata : lalu[cyc-1];
            lv[cyc]   = (bus.op_dec != 5'd0);
            lrw[cyc]  = bus.RW_dec;
            lalu[cyc] = bus.alu_res;
            lld[cyc]  = bus.mem_en_dec & ~bus.mem_rw_dec;
            lst[cyc]  = bus.mem_en_dec &  bus.mem_rw_dec;
            lsd[cyc]  = vb;
        end else begin
            lv[cyc] = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ua, ub, v;
        logic [7:0] ea, eb;
        int k;
        ea = model_fwd(bus.mux_sel_a, bus.rf_a, ua);
        eb = model_fwd(bus.mux_sel_b, bus.rf_b, ub);
        if (bus.imm_sel) eb = bus.Imm;
        check("opnd_a", bus.opnd_a, ea);
        check("opnd_b", bus.opnd_b, eb);
        check("op_ex", bus.op_ex, bus.op_dec);
        k = cyc - 1;
        v = mvalid(k);
        check("dm_en",    bus.dm_en,    v ? (lld[k] | lst[k]) : 1'b0);
        check("dm_we",    bus.dm_we,    v ? lst[k] : 1'b0);
        check("dm_addr",  bus.dm_addr,  v ? lalu[k] : 8'h00);
        check("dm_wdata", bus.dm_wdata, v ? lsd[k] : 8'h00);
        k = cyc - 3;
        v = mvalid(k);
        check("wb_we",   bus.wb_we,   v ? !lst[k] : 1'b0);
        check("wb_addr", bus.wb_addr, v ? lrw[k] : 5'd0);
        check("wb_data", bus.wb_data, v ? lmres[k] : 8'h00);
        check("fwd_cnt", bus.fwd_cnt, mcnt);
    end

    task automatic defaults();
        bus.mux_sel_a  = 2'b00;
        bus.mux_sel_b  = 2'b00;
        bus.imm_sel    = 1'b0;
        bus.Imm        = 8'h00;
        bus.op_dec     = 5'd0;
        bus.RW_dec     = 5'd0;
        bus.mem_en_dec = 1'b0;
        bus.mem_rw_dec = 1'b0;
        bus.rf_a       = 8'h00;
        bus.rf_b       = 8'h00;
        bus.alu_res    = 8'h00;
        bus.dm_rdata   = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        defaults();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        defaults();
        reset         = 1'b0;
        bus.rf_a      = 8'h11;
        bus.rf_b      = 8'h22;
        bus.mux_sel_a = 2'b11;
        bus.mux_sel_b = 2'b11;
        sample();
        sample();
        check("rst_opnd_a",  bus.opnd_a,  8'h11);
        check("rst_opnd_b",  bus.opnd_b,  8'h22);
        check("rst_wb_we",   bus.wb_we,   1'b0);
        check("rst_fwd_cnt", bus.fwd_cnt, 8'd0);
        check("rst_dm_en",   bus.dm_en,   1'b0);

        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.mux_sel_a = 2'b11;
            bus.mux_sel_b = 2'b11;
        end
        sample();
        check("bubbles_fwd_cnt", bus.fwd_cnt, 8'd0);

        // ADD then dependent instruction forwarding from EX
        tick();
        bus.op_dec = 5'd1; bus.RW_dec = 5'd3; bus.alu_res = 8'h05;
        tick();
        bus.op_dec = 5'd1; bus.RW_dec = 5'd4; bus.mux_sel_a = 2'b01; bus.alu_res = 8'h09;
        sample();
        check("add_fwd_opnd_a", bus.opnd_a, 8'h05);
        tick();
        tick();
        sample();
        check("add_wb_we",   bus.wb_we,   1'b1);
        check("add_wb_addr", bus.wb_addr, 5'd3);
        check("add_wb_data", bus.wb_data, 8'h05);
        check("add_fwd_cnt", bus.fwd_cnt, 8'd1);
        tick();

        // Load, then MEM-distance forward of the loaded data
        tick();
        bus.op_dec = 5'd2; bus.RW_dec = 5'd5; bus.mem_en_dec = 1'b1; bus.alu_res = 8'h40;
        tick();
        bus.dm_rdata = 8'hA7;
        sample();
        check("ld_dm_en",   bus.dm_en,   1'b1);
        check("ld_dm_we",   bus.dm_we,   1'b0);
        check("ld_dm_addr", bus.dm_addr, 8'h40);
        tick();
        bus.op_dec = 5'd1; bus.RW_dec = 5'd6; bus.mux_sel_b = 2'b10;
        sample();
        check("ld_fwd_opnd_b", bus.opnd_b, 8'hA7);
        tick();
        tick();

        // Store: immediate drives B, register B is the store data
        tick();
        bus.op_dec = 5'd3; bus.mem_en_dec = 1'b1; bus.mem_rw_dec = 1'b1;
        bus.rf_b = 8'h3C; bus.imm_sel = 1'b1; bus.Imm = 8'h10; bus.alu_res = 8'h20;
        sample();
        check("st_opnd_b", bus.opnd_b, 8'h10);
        tick();
        sample();
        check("st_dm_we",    bus.dm_we,    1'b1);
        check("st_dm_wdata", bus.dm_wdata, 8'h3C);
        check("st_dm_addr",  bus.dm_addr,  8'h20);
        tick();
        tick();
        sample();
        check("st_no_wb_we", bus.wb_we, 1'b0);

        // WB holds a bubble: fallback to rf_a, no count
        tick();
        bus.op_dec = 5'd1; bus.RW_dec = 5'd8; bus.mux_sel_a = 2'b11; bus.rf_a = 8'h77;
        sample();
        check("wbbub_opnd_a", bus.opnd_a, 8'h77);
        tick();
        sample();
        check("wbbub_fwd_cnt", bus.fwd_cnt, 8'd2);

        // Sustained dual forwarding drives the counter into saturation
        for (int i = 0; i < 200; i++) begin
            tick();
            bus.op_dec = 5'd1; bus.RW_dec = 5'd7;
            bus.mux_sel_a = 2'b01; bus.mux_sel_b = 2'b10;
            bus.alu_res = 8'(i * 3 + 1);
        end
        sample();
        check("sat_fwd_cnt", bus.fwd_cnt, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.op_dec = 5'd1; bus.RW_dec = 5'd7;
            bus.mux_sel_a = 2'b01; bus.mux_sel_b = 2'b01;
            bus.alu_res = 8'h5A;
        end
        sample();
        check("sat_hold_fwd_cnt", bus.fwd_cnt, 8'hFF);

        // Asynchronous reset mid-stream drops in-flight results
        tick();
        bus.op_dec = 5'd1; bus.RW_dec = 5'd9; bus.alu_res = 8'h55;
        tick();
        bus.op_dec = 5'd1; bus.RW_dec = 5'd10; bus.alu_res = 8'h66;
        #2 reset = 1'b0;
        #1;
        check("arst_wb_we",   bus.wb_we,   1'b0);
        check("arst_fwd_cnt", bus.fwd_cnt, 8'd0);
        check("arst_dm_en",   bus.dm_en,   1'b0);
        tick();
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            check("post_rst_wb_we", bus.wb_we, 1'b0);
        end
        check("post_rst_fwd_cnt", bus.fwd_cnt, 8'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
